// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: groups the request, ALU-arbiter and result signals of the
// HI/LO multiply/divide sequencer. The slave modport is the sequencer. The
// master modport is its environment: the EX stage, the arbiter and the ALU.
// Optional feature macro: HILO_CANCEL_EN adds the cancel (flush) input.
interface hilo_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out1;
  logic [31:0] alu_out2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef HILO_CANCEL_EN
  logic        cancel;

  modport master (
    output start, op, rs_val, rt_val, alu_gnt, alu_out1, alu_out2, cancel,
    input  alu_req, alu_control, alu_in1, alu_in2, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, alu_gnt, alu_out1, alu_out2, cancel,
    output alu_req, alu_control, alu_in1, alu_in2, hi, lo, busy, done, div_zero
  );
`else
  modport master (
    output start, op, rs_val, rt_val, alu_gnt, alu_out1, alu_out2,
    input  alu_req, alu_control, alu_in1, alu_in2, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, alu_gnt, alu_out1, alu_out2,
    output alu_req, alu_control, alu_in1, alu_in2, hi, lo, busy, done, div_zero
  );
`endif
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle multiply/divide sequencer on the shared ALU
// and owner of the architectural HI/LO registers.
// Optional feature macro: HILO_CANCEL_EN (cancel input flushes an operation).
// All outputs are registered. They are computed from the next state, so they
// line up exactly with the state the block is in.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic          clk,
  input logic          reset,
  hilo_muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_EXEC = 2'b10;
  localparam logic [1:0] S_DZ   = 2'b11;

  // The counter is loaded with LAT-1 and counts down to 0, so the block
  // spends exactly LAT cycles in EXEC.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  // ALU control code for a latched mult/div opcode (low two op bits).
  function automatic logic [3:0] alu_code(input logic [1:0] opc);
    logic [3:0] code;
    case (opc)
      2'b00:   code = 4'b1110;  // MULT
      2'b01:   code = 4'b1100;  // MULTU
      2'b10:   code = 4'b1111;  // DIV
      2'b11:   code = 4'b1101;  // DIVU
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_s;
  logic [1:0]  op_r;
  logic [31:0] opa_r;
  logic [31:0] opb_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
  logic        dz_r;
  logic        busy_r;
  logic        alu_req_r;
  logic [3:0]  alu_control_r;
  logic [31:0] alu_in1_r;
  logic [31:0] alu_in2_r;
  logic        accept_s;
  logic        capture_s;
  logic        done_s;
  logic        dz_s;
  logic        mthi_s;
  logic        mtlo_s;
  logic        cancel_s;

`ifdef HILO_CANCEL_EN
  assign cancel_s = bus.cancel;
`else
  assign cancel_s = 1'b0;
`endif

  // Next-state, counter and event decode for the sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    done_s    = 1'b0;
    dz_s      = 1'b0;
    mthi_s    = 1'b0;
    mtlo_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000, 3'b001: begin
              accept_s = 1'b1;
              state_s  = S_REQ;
            end
            3'b010, 3'b011: begin
              accept_s = 1'b1;
              // A zero divisor never touches the ALU.
              if (bus.rt_val == 32'd0) begin
                state_s = S_DZ;
              end else begin
                state_s = S_REQ;
              end
            end
            3'b100:  mthi_s = 1'b1;
            3'b101:  mtlo_s = 1'b1;
            default: state_s = S_IDLE;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (cancel_s) begin
          state_s = S_IDLE;
          cnt_s   = 6'd0;
        end else if (bus.alu_gnt) begin
          state_s = S_EXEC;
          cnt_s   = op_r[1] ? DIV_CNT : MUL_CNT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_EXEC: begin
        if (cancel_s) begin
          state_s = S_IDLE;
          cnt_s   = 6'd0;
        end else if (!bus.alu_gnt) begin
          // The ALU was taken away, so the partial run is worthless.
          // Go back and count the full latency again after regrant.
          state_s = S_REQ;
        end else if (cnt_r == 6'd0) begin
          capture_s = 1'b1;
          done_s    = 1'b1;
          state_s   = S_IDLE;
        end else begin
          cnt_s = cnt_r - 6'd1;
        end
      end
      S_DZ: begin
        state_s = S_IDLE;
        if (cancel_s) begin
          done_s = 1'b0;
          dz_s   = 1'b0;
        end else begin
          done_s = 1'b1;
          dz_s   = 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Latch the opcode and operands of an accepted mult/div request.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r  <= 2'b00;
      opa_r <= 32'd0;
      opb_r <= 32'd0;
    end else if (accept_s) begin
      op_r  <= bus.op[1:0];
      opa_r <= bus.rs_val;
      opb_r <= bus.rt_val;
    end
  end

  // HI/LO registers: written by ALU result capture or by MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (capture_s) begin
      hi_r <= bus.alu_out2;
      lo_r <= bus.alu_out1;
    end else begin
      if (mthi_s) begin
        hi_r <= bus.rs_val;
      end
      if (mtlo_s) begin
        lo_r <= bus.rs_val;
      end
    end
  end

  // Registered status and ALU-drive outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r        <= 1'b0;
      dz_r          <= 1'b0;
      busy_r        <= 1'b0;
      alu_req_r     <= 1'b0;
      alu_control_r <= 4'b0000;
      alu_in1_r     <= 32'd0;
      alu_in2_r     <= 32'd0;
    end else begin
      done_r    <= done_s;
      dz_r      <= dz_s;
      busy_r    <= (state_s != S_IDLE);
      alu_req_r <= (state_s == S_REQ) || (state_s == S_EXEC);
      if (state_s == S_EXEC) begin
        alu_control_r <= alu_code(op_r);
        alu_in1_r     <= opa_r;
        alu_in2_r     <= opb_r;
      end else begin
        alu_control_r <= 4'b0000;
        alu_in1_r     <= 32'd0;
        alu_in2_r     <= 32'd0;
      end
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.done        = done_r;
  assign bus.div_zero    = dz_r;
  assign bus.busy        = busy_r;
  assign bus.alu_req     = alu_req_r;
  assign bus.alu_control = alu_control_r;
  assign bus.alu_in1     = alu_in1_r;
  assign bus.alu_in2     = alu_in2_r;

endmodule
